// File: rtl/match_sequencer_if.sv
// match_sequencer_if: command/status bundle between match_sequencer and game_logic.
interface match_sequencer_if;
  logic ball_hold;
  logic ball_launch;
  logic launch_up;
  logic paddles_frozen;
  logic ball_out_of_bounds;
  logic ball_out_bottom;
  modport master (
    output ball_hold, ball_launch, launch_up, paddles_frozen,
    input  ball_out_of_bounds, ball_out_bottom
  );
  modport slave (
    input  ball_hold, ball_launch, launch_up, paddles_frozen,
    output ball_out_of_bounds, ball_out_bottom
  );
endinterface

// File: rtl/match_sequencer.sv
// match_sequencer: pong match controller sequencing attract, serve, play, point and game-over phases in frames.
module match_sequencer #(
  parameter logic [1:0] MAX_LIVES       = 2'd3,
  parameter logic [7:0] SERVE_FRAMES    = 8'd120,
  parameter logic [7:0] POINT_FRAMES    = 8'd60,
  parameter logic [7:0] GAMEOVER_FRAMES = 8'd180
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              frame_pulse,
  input  logic              p1_btn_select,
  input  logic              p2_btn_select,
  match_sequencer_if.master gl,
  output logic [1:0]        p1_lives,
  output logic [1:0]        p2_lives,
  output logic [2:0]        match_state,
  output logic              winner,
  output logic              miss_beep
);
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAY       = 3'd2,
    POINT      = 3'd3,
    GAME_OVER  = 3'd4
  } state_t;
  state_t     state, state_d;
  logic [7:0] cnt, cnt_d, load;
  logic [1:0] p1_d, p2_d;
  logic       server, server_d, loser, loser_d, winner_d;
  logic       up, up_d, launch, launch_d, beep_d, hold, frozen;
  logic       sel1_q, sel2_q, press1, press2, expired;
  assign press1  = p1_btn_select & ~sel1_q;
  assign press2  = p2_btn_select & ~sel2_q;
  assign expired = cnt == 8'd0;
  always_comb begin
    state_d  = state;
    p1_d     = p1_lives;
    p2_d     = p2_lives;
    server_d = server;
    loser_d  = loser;
    winner_d = winner;
    up_d     = up;
    launch_d = 1'b0;
    beep_d   = 1'b0;
    case (state)
      IDLE: if (press1 | press2) begin
        state_d  = SERVE_WAIT;
        p1_d     = MAX_LIVES;
        p2_d     = MAX_LIVES;
        server_d = 1'b0;
      end
      SERVE_WAIT: if (expired | (server ? press2 : press1)) begin
        state_d  = PLAY;
        launch_d = 1'b1;
        up_d     = ~server;
      end
      PLAY: if (gl.ball_out_of_bounds) begin
        state_d = POINT;
        beep_d  = 1'b1;
        loser_d = ~gl.ball_out_bottom;
        p1_d    = gl.ball_out_bottom ? p1_lives - 2'(p1_lives != 2'd0) : p1_lives;
        p2_d    = gl.ball_out_bottom ? p2_lives : p2_lives - 2'(p2_lives != 2'd0);
      end
      POINT: if (expired) begin
        if ((loser ? p2_lives : p1_lives) == 2'd0) begin
          state_d  = GAME_OVER;
          winner_d = ~loser;
        end else begin
          state_d  = SERVE_WAIT;
          server_d = loser;
        end
      end
      GAME_OVER: if (expired & (press1 | press2)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a fresh load on state entry wins over a coincident frame_pulse
    load  = state_d == SERVE_WAIT ? SERVE_FRAMES :
            state_d == POINT      ? POINT_FRAMES :
            state_d == GAME_OVER  ? GAMEOVER_FRAMES : 8'd0;
    cnt_d = state_d != state ? load : (frame_pulse && !expired) ? cnt - 8'd1 : cnt;
  end
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      p1_lives <= MAX_LIVES;
      p2_lives <= MAX_LIVES;
      server   <= 1'b0;
      loser    <= 1'b0;
      winner   <= 1'b0;
      up       <= 1'b1;
      launch   <= 1'b0;
      miss_beep <= 1'b0;
      hold     <= 1'b1;
      frozen   <= 1'b1;
      sel1_q   <= 1'b1;
      sel2_q   <= 1'b1;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      p1_lives <= p1_d;
      p2_lives <= p2_d;
      server   <= server_d;
      loser    <= loser_d;
      winner   <= winner_d;
      up       <= up_d;
      launch   <= launch_d;
      miss_beep <= beep_d;
      hold     <= state_d != PLAY;
      frozen   <= state_d != SERVE_WAIT && state_d != PLAY;
      sel1_q   <= p1_btn_select;
      sel2_q   <= p2_btn_select;
    end
  end
  assign match_state       = state;
  assign gl.ball_hold      = hold;
  assign gl.ball_launch    = launch;
  assign gl.launch_up      = up;
  assign gl.paddles_frozen = frozen;
endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: directed checks of match_sequencer with short frame timings.
module tb_match_sequencer;
  logic       clk = 1'b0;
  logic       nRst, frame_pulse, p1_btn_select, p2_btn_select;
  logic [1:0] p1_lives, p2_lives;
  logic [2:0] match_state;
  logic       winner, miss_beep;
  int         checks = 0;
  int         errors = 0;
  match_sequencer_if gl();
  match_sequencer #(
    .MAX_LIVES(2'd3), .SERVE_FRAMES(8'd4), .POINT_FRAMES(8'd3), .GAMEOVER_FRAMES(8'd5)
  ) dut (
    .clk(clk), .nRst(nRst), .frame_pulse(frame_pulse),
    .p1_btn_select(p1_btn_select), .p2_btn_select(p2_btn_select),
    .gl(gl), .p1_lives(p1_lives), .p2_lives(p2_lives),
    .match_state(match_state), .winner(winner), .miss_beep(miss_beep)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic frames(input int n);
    repeat (n) begin
      frame_pulse = 1'b1;
      tick();
      frame_pulse = 1'b0;
    end
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    nRst = 1'b0; frame_pulse = 1'b0; p1_btn_select = 1'b1; p2_btn_select = 1'b0;
    gl.ball_out_of_bounds = 1'b0; gl.ball_out_bottom = 1'b0;
    tick(2);
    chk("rst_state", match_state, 0);
    chk("rst_p1_lives", p1_lives, 3);
    chk("rst_p2_lives", p2_lives, 3);
    chk("rst_hold", gl.ball_hold, 1);
    chk("rst_frozen", gl.paddles_frozen, 1);
    chk("rst_launch", gl.ball_launch, 0);
    chk("rst_up", gl.launch_up, 1);
    chk("rst_beep", miss_beep, 0);
    chk("rst_winner", winner, 0);
    nRst = 1'b1;
    tick();
    chk("held_not_press", match_state, 0);
    p1_btn_select = 1'b0; tick();
    p1_btn_select = 1'b1; tick();
    chk("idle_to_serve", match_state, 1);
    chk("serve_hold", gl.ball_hold, 1);
    chk("serve_frozen", gl.paddles_frozen, 0);
    tick();
    chk("held_no_launch", gl.ball_launch, 0);
    p1_btn_select = 1'b0;
    p2_btn_select = 1'b1; tick();
    chk("nonserver_state", match_state, 1);
    chk("nonserver_launch", gl.ball_launch, 0);
    p2_btn_select = 1'b0;
    frames(4);
    chk("serve_4frames_state", match_state, 1);
    chk("serve_4frames_launch", gl.ball_launch, 0);
    tick();
    chk("auto_launch", gl.ball_launch, 1);
    chk("auto_play", match_state, 2);
    chk("auto_hold", gl.ball_hold, 0);
    chk("auto_up", gl.launch_up, 1);
    chk("play_frozen", gl.paddles_frozen, 0);
    tick();
    chk("launch_once", gl.ball_launch, 0);
    gl.ball_out_of_bounds = 1'b1; gl.ball_out_bottom = 1'b1;
    tick();
    chk("p1miss_state", match_state, 3);
    chk("p1miss_beep", miss_beep, 1);
    chk("p1miss_lives", p1_lives, 2);
    chk("point_hold", gl.ball_hold, 1);
    chk("point_frozen", gl.paddles_frozen, 1);
    tick();
    chk("beep_once", miss_beep, 0);
    tick(8);
    gl.ball_out_of_bounds = 1'b0;
    chk("p1miss_single", p1_lives, 2);
    chk("p1miss_p2lives", p2_lives, 3);
    chk("point_wait", match_state, 3);
    frames(3);
    tick();
    chk("point_to_serve", match_state, 1);
    p1_btn_select = 1'b1; tick();
    chk("p1_press_launch", gl.ball_launch, 1);
    chk("p1_press_play", match_state, 2);
    chk("p1_server_up", gl.launch_up, 1);
    p1_btn_select = 1'b0;
    gl.ball_out_of_bounds = 1'b1; gl.ball_out_bottom = 1'b0;
    tick();
    gl.ball_out_of_bounds = 1'b0;
    chk("p2miss1_lives", p2_lives, 2);
    chk("p2miss1_beep", miss_beep, 1);
    frames(3);
    tick();
    chk("p2serve_state", match_state, 1);
    chk("up_stable", gl.launch_up, 1);
    p1_btn_select = 1'b1; tick();
    chk("p1_nonserver", match_state, 1);
    chk("p1_nonserver_launch", gl.ball_launch, 0);
    p1_btn_select = 1'b0;
    p2_btn_select = 1'b1; tick();
    chk("p2_press_launch", gl.ball_launch, 1);
    chk("p2_server_up", gl.launch_up, 0);
    p2_btn_select = 1'b0;
    gl.ball_out_of_bounds = 1'b1;
    tick();
    gl.ball_out_of_bounds = 1'b0;
    chk("p2miss2_lives", p2_lives, 1);
    frames(3);
    tick();
    frames(4);
    chk("simul_pre", match_state, 1);
    p2_btn_select = 1'b1; tick();
    chk("simul_launch", gl.ball_launch, 1);
    tick();
    chk("simul_one_launch", gl.ball_launch, 0);
    chk("simul_play", match_state, 2);
    p2_btn_select = 1'b0;
    gl.ball_out_of_bounds = 1'b1;
    tick();
    gl.ball_out_of_bounds = 1'b0;
    chk("p2miss3_lives", p2_lives, 0);
    frames(3);
    frame_pulse = 1'b1; tick(); frame_pulse = 1'b0;
    chk("gameover_state", match_state, 4);
    chk("gameover_winner", winner, 0);
    chk("gameover_p1", p1_lives, 2);
    frames(4);
    p1_btn_select = 1'b1; tick();
    p1_btn_select = 1'b0; tick();
    chk("early_press_ignored", match_state, 4);
    frames(1);
    p2_btn_select = 1'b1; tick();
    chk("gameover_to_idle", match_state, 0);
    chk("idle_p2_not_reloaded", p2_lives, 0);
    chk("idle_p1_not_reloaded", p1_lives, 2);
    p2_btn_select = 1'b0; tick();
    p1_btn_select = 1'b1; tick();
    chk("reload_state", match_state, 1);
    chk("reload_p1", p1_lives, 3);
    chk("reload_p2", p2_lives, 3);
    p1_btn_select = 1'b0; tick();
    p1_btn_select = 1'b1; tick();
    p1_btn_select = 1'b0; tick();
    chk("midplay_state", match_state, 2);
    nRst = 1'b0; gl.ball_out_of_bounds = 1'b1;
    tick();
    chk("midrst_state", match_state, 0);
    chk("midrst_hold", gl.ball_hold, 1);
    chk("midrst_launch", gl.ball_launch, 0);
    chk("midrst_beep", miss_beep, 0);
    chk("midrst_p1", p1_lives, 3);
    chk("midrst_p2", p2_lives, 3);
    nRst = 1'b1; gl.ball_out_of_bounds = 1'b0;
    tick();
    chk("postrst_idle", match_state, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
- Top-level match controller for the pong game; sequences attract, serve, play, point-scored and game-over phases.
- Owns both players' lives counters and the serving player.
- Commands game_logic: hold/recenter the ball, launch it with a direction, freeze paddles.
- Runs on the pixel clock; all timing is counted in frames via the VGA frame_pulse.

Parameters:
- MAX_LIVES, 2'd3, lives loaded at match start (1..3).
- SERVE_FRAMES, 8'd120, frames before auto-launch in SERVE_WAIT.
- POINT_FRAMES, 8'd60, frames held in POINT after a miss.
- GAMEOVER_FRAMES, 8'd180, minimum frames in GAME_OVER before select is accepted.

Ports:
- clk  in  1  pixel clock
- nRst  in  1  synchronous active-low reset
- frame_pulse  in  1  one-cycle pulse per frame from vga_timing
- p1_btn_select  in  1  synchronized level, player 1 select
- p2_btn_select  in  1  synchronized level, player 2 select
- ball_out_of_bounds  in  1  level from game_logic, ball has left the field
- ball_out_bottom  in  1  qualifies ball_out_of_bounds: 1 = bottom edge (p1 missed), 0 = top edge (p2 missed)
- ball_hold  out  1  1 = game_logic holds the ball at INITIAL_BALL_X/Y
- ball_launch  out  1  one-cycle launch pulse
- launch_up  out  1  launch direction: 1 = toward p2 (top), 0 = toward p1
- paddles_frozen  out  1  1 = paddle movement ignored
- p1_lives  out  2  player 1 lives
- p2_lives  out  2  player 2 lives
- match_state  out  3  encoded state: 0 IDLE, 1 SERVE_WAIT, 2 PLAY, 3 POINT, 4 GAME_OVER
- winner  out  1  0 = p1, 1 = p2; valid in GAME_OVER only
- miss_beep  out  1  one-cycle pulse on entry to POINT, for sound_gen low_beep

Behaviour:
- Clock and reset: single clock clk; reset nRst is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - state IDLE, both lives = MAX_LIVES, server = p1, frame counter 0.
  - ball_hold = 1, paddles_frozen = 1, ball_launch = 0, miss_beep = 0, launch_up = 1, winner = 0.
- All outputs are registered. Reset is honoured mid-state and overrides every other input.
- Select edge detection:
  - One register per button; press = level high and previous sample low.
  - A held button never produces a second press.
  - The edge registers reset to 1, so a button held through reset is not a press.
- Frame counter:
  - 8-bit. Loaded on every state entry.
  - Decrements on frame_pulse and saturates at 0.
  - "Expired" means count == 0.
- IDLE:
  - ball_hold = 1, paddles_frozen = 1.
  - A press from either player loads lives = MAX_LIVES for both, sets server = p1, moves to SERVE_WAIT and loads SERVE_FRAMES.
- SERVE_WAIT:
  - ball_hold = 1, paddles_frozen = 0.
  - Leave for PLAY when the counter expires or the serving player presses select. A non-server press is ignored.
  - On entry to PLAY: ball_launch = 1 for exactly one cycle and ball_hold = 0 in the same cycle.
  - launch_up = 1 if the server is p1, 0 if the server is p2. launch_up is held stable until the next launch.
- PLAY:
  - ball_hold = 0.
  - When ball_out_of_bounds = 1, the loser is p1 if ball_out_bottom = 1, else p2.
  - The loser's lives decrement by 1 and saturate at 0.
  - miss_beep pulses for one cycle, then the state moves to POINT and loads POINT_FRAMES.
  - ball_out_of_bounds is ignored in every other state, and only its first cycle in PLAY counts (a single transition).
- POINT:
  - ball_hold = 1, paddles_frozen = 1.
  - When the counter expires: if the loser's lives == 0, go to GAME_OVER, load GAMEOVER_FRAMES and set winner = the other player.
  - Otherwise set server = loser and go to SERVE_WAIT, loading SERVE_FRAMES.
- GAME_OVER:
  - ball_hold = 1, paddles_frozen = 1; lives frozen.
  - After expiry, any press moves to IDLE without reloading lives; lives are reloaded on leaving IDLE.
  - Presses before expiry are discarded.
- Simultaneous events:
  - A frame_pulse in the same cycle as a state entry does not decrement the freshly loaded count.
  - A select press and counter expiry in the same SERVE_WAIT cycle produce one launch only.

Test Plan:
- Reset with nRst = 0 for 2 cycles while p1_btn_select is held high -> IDLE, lives 3/3, ball_hold = 1, ball_launch = 0. Release and press again -> SERVE_WAIT.
- SERVE_FRAMES = 4, no presses -> ball_launch pulses exactly once, 1 cycle after the 4th frame_pulse; launch_up = 1; state PLAY.
- In SERVE_WAIT with server p1, p2 presses select -> no launch. p1 presses -> launch on the next cycle.
- PLAY, assert ball_out_of_bounds = 1 with ball_out_bottom = 1 for 10 cycles -> p1_lives 3 -> 2 once, miss_beep one cycle. After POINT_FRAMES, server = p1.
- p2 misses three times -> p2_lives 0, GAME_OVER, winner = 0. A press before GAMEOVER_FRAMES expires is ignored; a press after goes to IDLE, then the next press reloads lives 3/3.
- Drop nRst for one cycle mid-PLAY -> next cycle IDLE, lives 3/3, ball_hold = 1, no ball_launch or miss_beep pulse.
